// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch next-PC path: data width, reset PC and
// the 2-bit branch-history counter encoding with its saturating update.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != ST) res = ctr + 2'd1;
        end else begin
            if (ctr != SNT) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: one combinational
// read port (prediction bit) and one synchronous update port.
module bht_2bit
    import fetch_pkg::*;
#(
    parameter int BHT_ENTRIES = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [BHT_ENTRIES-1:0] taken_bits;

    // Each counter is its own register so the whole table resets at once.
    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_ctr
        logic [1:0] ctr_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ctr_q <= WNT;
            end else if (upd_en && (upd_idx == IDX_W'(gi))) begin
                ctr_q <= sat_update(ctr_q, upd_taken);
            end
        end

        assign taken_bits[gi] = ctr_q[1];
    end

    assign rd_taken = taken_bits[rd_idx];

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage next-PC generator: owns PC_F, gates BTB hits with the BHT,
// resolves E-stage mispredictions and keeps branch/mispredict counters.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int              BHT_ENTRIES = 256,
    parameter int              IDX_W       = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_F,
    input  logic            btb_hit,
    input  logic [XLEN-1:0] btb_target,
    input  logic            valid_E,
    input  logic            branch_E,
    input  logic            jump_E,
    input  logic            taken_E,
    input  logic [XLEN-1:0] pc_E,
    input  logic [XLEN-1:0] pc_target_E,
    input  logic            pred_taken_E,
    input  logic [XLEN-1:0] pred_target_E,
    output logic [XLEN-1:0] pc_F,
    output logic            pred_taken_F,
    output logic [XLEN-1:0] pred_target_F,
    output logic            flush_D,
    output logic            flush_E,
    output logic [XLEN-1:0] br_count,
    output logic [XLEN-1:0] mp_count
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] br_count_q, br_count_d;
    logic [XLEN-1:0] mp_count_q, mp_count_d;
    logic [XLEN-1:0] pc_plus4, correct_pc;
    logic            bht_pred, act_taken, mispredict, bht_upd;

    bht_2bit #(
        .BHT_ENTRIES(BHT_ENTRIES),
        .IDX_W      (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pc_q[IDX_W+1:2]),
        .rd_taken (bht_pred),
        .upd_en   (bht_upd),
        .upd_idx  (pc_E[IDX_W+1:2]),
        .upd_taken(act_taken)
    );

    always_comb begin
        act_taken  = jump_E | (branch_E & taken_E);
        // A taken prediction on a non-branch (BTB alias) falls out as act_taken=0.
        mispredict = valid_E & ((act_taken != pred_taken_E) |
                                (act_taken & pred_taken_E & (pred_target_E != pc_target_E)));
        bht_upd    = valid_E & (branch_E | jump_E);
        pc_plus4   = pc_q + 32'd4;
        correct_pc = act_taken ? pc_target_E : (pc_E + 32'd4);
    end

    always_comb begin
        pred_taken_F  = ~rst & btb_hit & bht_pred;
        pred_target_F = pred_taken_F ? btb_target : pc_plus4;
        flush_D       = ~rst & mispredict;
        flush_E       = ~rst & mispredict;

        pc_d = pc_plus4;
        if (mispredict) begin
            pc_d = correct_pc;
        end else if (stall_F) begin
            pc_d = pc_q;
        end else if (pred_taken_F) begin
            pc_d = btb_target;
        end
        pc_d[1:0] = 2'b00;

        br_count_d = br_count_q + {31'd0, bht_upd};
        mp_count_d = mp_count_q + {31'd0, mispredict};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            br_count_q <= '0;
            mp_count_q <= '0;
        end else begin
            pc_q       <= pc_d;
            br_count_q <= br_count_d;
            mp_count_q <= mp_count_d;
        end
    end

    assign pc_F     = pc_q;
    assign br_count = br_count_q;
    assign mp_count = mp_count_q;

endmodule
